// File: rtl/imem_loader.sv
// Instruction memory loader: accepts a framed byte stream (length, big-endian
// words, XOR checksum), writes words to imem and releases CPU reset on success.
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [31:0]           o_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic                  o_cpu_rst_n
);

  // state   | meaning
  // S_IDLE  | waiting for i_start after reset
  // S_LEN_HI| expecting word-count high byte
  // S_LEN_LO| expecting word-count low byte, range check
  // S_DATA  | assembling and writing data words
  // S_CSUM  | expecting checksum byte
  // S_DONE  | image loaded and verified, CPU released
  // S_ERR   | length overflow or checksum mismatch
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam int WCW = $clog2(DEPTH) + 1;

  state_t          state, state_nxt;
  logic [7:0]      len_hi;
  logic [15:0]     len;
  logic [WCW-1:0]  word_cnt;
  logic [1:0]      byte_cnt;
  logic [7:0]      csum;
  logic [23:0]     shreg;
  logic            xfer;
  logic            start_acc;
  logic [15:0]     len_n;
  logic            last_word;

  assign xfer      = i_byte_valid && o_byte_ready;
  assign len_n     = {len_hi, i_byte};
  assign start_acc = i_start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign last_word = (32'(word_cnt) + 32'd1) == {16'd0, len};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (i_start) state_nxt = S_LEN_HI;
      S_LEN_HI: if (xfer) state_nxt = S_LEN_LO;
      S_LEN_LO: if (xfer) begin
        if (len_n == 16'd0)                    state_nxt = S_CSUM;
        else if ({16'd0, len_n} > 32'(DEPTH))  state_nxt = S_ERR;
        else                                   state_nxt = S_DATA;
      end
      S_DATA: if (xfer && byte_cnt == 2'd3 && last_word) state_nxt = S_CSUM;
      S_CSUM: if (xfer) state_nxt = (i_byte == csum) ? S_DONE : S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                        (state == S_DATA)   || (state == S_CSUM);
  assign o_busy       = o_byte_ready;
  assign o_done       = (state == S_DONE);
  assign o_error      = (state == S_ERR);
  assign o_cpu_rst_n  = (state == S_DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      len_hi   <= '0;
      len      <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      csum     <= '0;
      shreg    <= '0;
      o_we     <= 1'b0;
      o_addr   <= '0;
      o_wdata  <= '0;
    end else begin
      o_we <= 1'b0;
      if (start_acc) begin
        word_cnt <= '0;
        byte_cnt <= '0;
        csum     <= '0;
      end
      case (state)
        S_LEN_HI: if (xfer) len_hi <= i_byte;
        S_LEN_LO: if (xfer) len <= len_n;
        S_DATA: if (xfer) begin
          csum     <= csum ^ i_byte;
          byte_cnt <= byte_cnt + 2'd1;
          shreg    <= {shreg[15:0], i_byte};
          // Fourth byte completes the word; write it next cycle.
          if (byte_cnt == 2'd3) begin
            o_we     <= 1'b1;
            o_addr   <= ADDR_WIDTH'({word_cnt, 2'b00});
            o_wdata  <= {shreg, i_byte};
            word_cnt <= word_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
